// File: rtl/fp_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Purpose  : Size constants and shared types for the FP add/sub back end.
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

  localparam int DATA_SIZE     = 32;
  localparam int FRACTION_SIZE = 23;
  localparam int MANTISSA_SIZE = FRACTION_SIZE + 1;
  localparam int ROUNDING_SIZE = MANTISSA_SIZE + 3;
  localparam int EXPONENT_SIZE = 8;
  localparam int EXP_WIDTH     = EXPONENT_SIZE + 2;
  localparam int LZC_WIDTH     = 5;

  localparam int EXP_MAX  = 255;
  localparam int EXP_BIAS = 127;

  localparam logic [DATA_SIZE-1:0] POS_ZERO = '0;
  localparam logic [DATA_SIZE-2:0] INF_MAG  = {8'hFF, 23'h0};

  // Normalized operand held between the normalize and round stages.
  typedef struct packed {
    logic                        sign;
    logic [ROUNDING_SIZE-1:0]    norm;
    logic signed [EXP_WIDTH-1:0] exp;
    logic                        zero;
    logic                        uf;
  } norm_t;

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp_lzc
//  Purpose  : Combinational leading-zero counter; all-zero input yields WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module fp_lzc #(
  parameter int WIDTH     = 27,
  parameter int CNT_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     in_bits,
  output logic [CNT_WIDTH-1:0] count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    count = CNT_WIDTH'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_bits[i]) begin
        count = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_addsub_normalize_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fp_addsub_normalize_round
//  Purpose  : Normalize, round-to-nearest-even and pack an FP add/sub sum;
//             two register stages with a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fp_addsub_normalize_round
  import fp_pkg::*;
(
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [ROUNDING_SIZE:0]     Sum,
  input  logic [EXPONENT_SIZE-1:0]   ExponentBase,
  input  logic                       ResultSign,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [DATA_SIZE-1:0]       Result,
  output logic                       Overflow,
  output logic                       Underflow,
  output logic                       Inexact
);

  logic en_a, en_b;
  logic valid_a_q, valid_a_d;
  norm_t stage_a_q, stage_a_d, norm_a;
  logic out_valid_q, out_valid_d;
  logic [DATA_SIZE-1:0] result_q, result_d, result_b;
  logic ovf_q, ovf_d, ovf_b;
  logic uf_q, uf_d, uf_b;
  logic inx_q, inx_d, inx_b;

  logic [LZC_WIDTH-1:0] lz;
  logic signed [EXP_WIDTH-1:0] exp_base;

  assign en_b    = !out_valid_q || OutReady;
  assign en_a    = !valid_a_q || en_b;
  assign InReady = en_a;

  fp_lzc #(
    .WIDTH     (ROUNDING_SIZE),
    .CNT_WIDTH (LZC_WIDTH)
  ) u_lzc (
    .in_bits (Sum[ROUNDING_SIZE-1:0]),
    .count   (lz)
  );

  assign exp_base = $signed({2'b00, ExponentBase});

  // Stage A: carry right-shift (lost bit folded into sticky) or LZC left-shift.
  always_comb begin
    norm_a      = '0;
    norm_a.sign = ResultSign;
    if (Sum[ROUNDING_SIZE]) begin
      norm_a.norm = {Sum[ROUNDING_SIZE:2], Sum[1] | Sum[0]};
      norm_a.exp  = exp_base + 10'sd1;
    end else begin
      norm_a.norm = Sum[ROUNDING_SIZE-1:0] << lz;
      norm_a.exp  = exp_base - $signed({5'b00000, lz});
    end
    norm_a.zero = (Sum == '0);
    norm_a.uf   = !norm_a.zero && (norm_a.exp <= 0);
  end

  logic [MANTISSA_SIZE-1:0]    mant;
  logic                        g_bit, r_bit, s_bit, round_up;
  logic [MANTISSA_SIZE:0]      rounded;
  logic [FRACTION_SIZE-1:0]    frac_r;
  logic signed [EXP_WIDTH-1:0] exp_r;

  // Stage B: round to nearest even, renormalize a rounding carry, pack.
  always_comb begin
    mant     = stage_a_q.norm[ROUNDING_SIZE-1:3];
    g_bit    = stage_a_q.norm[2];
    r_bit    = stage_a_q.norm[1];
    s_bit    = stage_a_q.norm[0];
    round_up = g_bit && (mant[0] || r_bit || s_bit);
    rounded  = {1'b0, mant} + {{MANTISSA_SIZE{1'b0}}, round_up};
    if (rounded[MANTISSA_SIZE]) begin
      frac_r = rounded[MANTISSA_SIZE-1:1];
      exp_r  = stage_a_q.exp + 10'sd1;
    end else begin
      frac_r = rounded[FRACTION_SIZE-1:0];
      exp_r  = stage_a_q.exp;
    end

    result_b = {stage_a_q.sign, exp_r[EXPONENT_SIZE-1:0], frac_r};
    ovf_b    = 1'b0;
    uf_b     = 1'b0;
    inx_b    = g_bit || r_bit || s_bit;
    if (stage_a_q.zero) begin
      result_b = POS_ZERO;
      inx_b    = 1'b0;
    end else if (stage_a_q.uf) begin
      result_b = POS_ZERO;
      uf_b     = 1'b1;
      inx_b    = 1'b1;
    end else if (exp_r >= EXP_MAX) begin
      result_b = {stage_a_q.sign, INF_MAG};
      ovf_b    = 1'b1;
      inx_b    = 1'b1;
    end
  end

  always_comb begin
    valid_a_d   = en_a ? InValid : valid_a_q;
    stage_a_d   = (en_a && InValid) ? norm_a : stage_a_q;
    out_valid_d = en_b ? valid_a_q : out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    uf_d        = uf_q;
    inx_d       = inx_q;
    if (en_b && valid_a_q) begin
      result_d = result_b;
      ovf_d    = ovf_b;
      uf_d     = uf_b;
      inx_d    = inx_b;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_a_q   <= 1'b0;
      stage_a_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      uf_q        <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      valid_a_q   <= valid_a_d;
      stage_a_q   <= stage_a_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      uf_q        <= uf_d;
      inx_q       <= inx_d;
    end
  end

  assign OutValid  = out_valid_q;
  assign Result    = result_q;
  assign Overflow  = ovf_q;
  assign Underflow = uf_q;
  assign Inexact   = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_normalize_round.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fp_addsub_normalize_round
//  Purpose  : Directed self-checking bench for fp_addsub_normalize_round.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_addsub_normalize_round;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InValid;
  logic        InReady;
  logic [27:0] Sum;
  logic [7:0]  ExponentBase;
  logic        ResultSign;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] Result;
  logic        Overflow;
  logic        Underflow;
  logic        Inexact;

  always #5 Clk = ~Clk;

  fp_addsub_normalize_round dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .InValid      (InValid),
    .InReady      (InReady),
    .Sum          (Sum),
    .ExponentBase (ExponentBase),
    .ResultSign   (ResultSign),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .Result       (Result),
    .Overflow     (Overflow),
    .Underflow    (Underflow),
    .Inexact      (Inexact)
  );

  typedef struct packed {
    logic [27:0] sum;
    logic [7:0]  base;
    logic        sign;
    logic [31:0] res;
    logic        ovf;
    logic        uf;
    logic        inx;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected result is queued when an input is accepted.
  logic [34:0] sb [$];
  bit          mon_en  = 1'b0;
  int          cur_idx = 0;
  int          popped  = 0;

  always @(negedge Clk) begin
    if (mon_en && Rst_n) begin
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check($sformatf("out%0d", popped), {29'd0, Result, Overflow, Underflow, Inexact},
                {29'd0, sb.pop_front()});
          popped++;
        end
      end
      if (InValid && InReady) begin
        sb.push_back({vecs[cur_idx].res, vecs[cur_idx].ovf, vecs[cur_idx].uf, vecs[cur_idx].inx});
      end
    end
  end

  task automatic drive(input int i);
    cur_idx      = i;
    Sum          = vecs[i].sum;
    ExponentBase = vecs[i].base;
    ResultSign   = vecs[i].sign;
    InValid      = 1'b1;
  endtask

  task automatic send_single(input int i);
    drive(i);
    @(negedge Clk);
    check($sformatf("accept%0d", i), {63'd0, InReady}, 64'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    check($sformatf("lat1_%0d", i), {63'd0, OutValid}, 64'd0);
    @(negedge Clk);
    check($sformatf("lat2_%0d", i), {63'd0, OutValid}, 64'd1);
    @(posedge Clk); #1;
  endtask

  task automatic drain(input string tag, output int n);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check(tag, {32'd0, sb.size()}, 64'd0);
  endtask

  initial begin
    int k, stalls, base_pop, n;

    vecs[0]  = '{28'h8000000, 8'd127, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{28'h0200000, 8'd127, 1'b0, 32'h3D000000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{28'h0000000, 8'd127, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{28'h4000004, 8'd127, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{28'h400000C, 8'd127, 1'b0, 32'h3F800002, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{28'h7FFFFFC, 8'd254, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{28'h0000008, 8'd10,  1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{28'h4000006, 8'd127, 1'b1, 32'hBF800001, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{28'hC000003, 8'd100, 1'b0, 32'h32C00000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{28'h4000000, 8'd0,   1'b0, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{28'h4000000, 8'd1,   1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{28'h8000000, 8'd254, 1'b1, 32'hFF800000, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{28'h7FFFFF8, 8'd254, 1'b0, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0};

    Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    Sum = '0; ExponentBase = '0; ResultSign = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_outvalid", {63'd0, OutValid}, 64'd0);
    check("rst_result",   {32'd0, Result}, 64'd0);
    check("rst_flags",    {61'd0, Overflow, Underflow, Inexact}, 64'd0);
    check("rst_inready",  {63'd0, InReady}, 64'd1);
    @(posedge Clk); #1;
    Rst_n  = 1'b1;
    mon_en = 1'b1;

    // Isolated vectors with latency checks.
    for (int i = 0; i < NVEC; i++) send_single(i);
    drain("drain_single", n);

    // Back-to-back stream with OutReady held high.
    base_pop = popped;
    stalls   = 0;
    for (int i = 0; i < NVEC; i++) begin
      drive(i);
      @(negedge Clk);
      if (!InReady) stalls++;
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    drain("drain_stream", n);
    check("stream_stalls", {32'd0, stalls}, 64'd0);
    check("stream_count",  {32'd0, popped - base_pop}, NVEC);
    check("stream_tail",   {32'd0, n}, 64'd2);

    // Backpressure: OutReady low for five cycles while three inputs are offered.
    base_pop = popped;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      OutReady = (c >= 5);
      if (k < 3) drive(3 + k);
      else       InValid = 1'b0;
      @(negedge Clk);
      if (c == 4) begin
        check("stall_accepts", {32'd0, k}, 64'd2);
        check("stall_inready", {63'd0, InReady}, 64'd0);
      end
      if (InValid && InReady) k++;
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    check("bp_accepted", {32'd0, k}, 64'd3);
    check("bp_count",    {32'd0, popped - base_pop}, 64'd3);
    drain("drain_bp", n);

    // Fill the pipe, then assert reset asynchronously.
    OutReady = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(7 + c);
      @(posedge Clk); #1;
    end
    InValid = 1'b0;
    @(posedge Clk); #2;
    check("full_outvalid", {63'd0, OutValid}, 64'd1);
    mon_en = 1'b0;
    Rst_n  = 1'b0;
    #1;
    check("arst_outvalid", {63'd0, OutValid}, 64'd0);
    check("arst_result",   {32'd0, Result}, 64'd0);
    check("arst_flags",    {61'd0, Overflow, Underflow, Inexact}, 64'd0);
    check("arst_inready",  {63'd0, InReady}, 64'd1);
    sb.delete();
    @(posedge Clk); #1;
    Rst_n    = 1'b1;
    OutReady = 1'b1;
    mon_en   = 1'b1;
    send_single(1);
    drain("drain_post_rst", n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
